// File: rtl/mem_responder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_responder_pkg                                                          |
// | Shared types, constants and address helper for the memory responder.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package mem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        RESP  = 2'd2,
        RECOV = 2'd3
    } state_e;

    localparam logic [15:0] ERR_PATTERN = 16'hDEAD;

    // Wide result so any ADDR_WIDTH up to 64 can be range-checked without truncation.
    function automatic logic [63:0] word_idx(input logic [63:0] adr, input int unsigned off_bits);
        return adr >> off_bits;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_responder_sram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_responder_sram                                                         |
// | DEPTH x DATA_WIDTH storage, one synchronous write and one synchronous read. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_responder_sram #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned AW         = 10
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic                  re_i,
    input  logic [AW-1:0]         addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // No reset on purpose: this block is meant to be swapped for a foundry macro.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_responder                                                              |
// | Memory-side responder with programmable latency for the cache memory port.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned LATENCY    = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  mem_valid_i,
    output logic                  mem_ready_o,
    input  logic                  mem_we_i,
    input  logic [ADDR_WIDTH-1:0] mem_adr_i,
    input  logic [DATA_WIDTH-1:0] mem_wdata_i,
    output logic [DATA_WIDTH-1:0] mem_rdata_o,
    output logic                  err_o
);

    localparam int unsigned           OFF_BITS = $clog2(DATA_WIDTH / 8);
    localparam int unsigned           SRAM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]            CNT_INIT = 4'(LATENCY - 1);
    localparam logic [DATA_WIDTH-1:0] ERR_WORD = {(DATA_WIDTH / 16){ERR_PATTERN}};

    state_e                  state_q;
    logic [3:0]              cnt_q;
    logic [3:0]              cnt_d;
    logic                    we_q;
    logic [ADDR_WIDTH-1:0]   adr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic                    ready_q;
    logic                    rd_q;
    logic                    oor_q;
    logic                    err_q;

    logic                    accept;
    logic                    commit;
    logic                    acc_we;
    logic [ADDR_WIDTH-1:0]   acc_adr;
    logic [DATA_WIDTH-1:0]   acc_wdata;
    logic [63:0]             idx;
    logic                    oor;
    logic [DATA_WIDTH-1:0]   sram_rdata;

    assign accept = (state_q == IDLE) && mem_valid_i;

    // With LATENCY=1 the storage access happens on the acceptance edge itself, so the
    // live request fields are used; otherwise the latched copy drives the access.
    assign acc_we    = (state_q == IDLE) ? mem_we_i    : we_q;
    assign acc_adr   = (state_q == IDLE) ? mem_adr_i   : adr_q;
    assign acc_wdata = (state_q == IDLE) ? mem_wdata_i : wdata_q;

    assign commit = (accept && (LATENCY == 1)) ||
                    ((state_q == WAIT) && (cnt_q <= 4'd1));

    assign idx   = word_idx({{(64 - ADDR_WIDTH){1'b0}}, acc_adr}, OFF_BITS);
    assign oor   = (idx >= 64'(DEPTH));
    assign cnt_d = cnt_q - 4'd1;

    mem_responder_sram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (SRAM_AW)
    ) u_sram (
        .clk_i   (clk_i),
        .we_i    (commit && acc_we && !oor),
        .re_i    (commit && !acc_we && !oor),
        .addr_i  (idx[SRAM_AW-1:0]),
        .wdata_i (acc_wdata),
        .rdata_o (sram_rdata)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            wdata_q <= '0;
            ready_q <= 1'b0;
            rd_q    <= 1'b0;
            oor_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mem_valid_i) begin
                        we_q    <= mem_we_i;
                        adr_q   <= mem_adr_i;
                        wdata_q <= mem_wdata_i;
                        cnt_q   <= CNT_INIT;
                        if (LATENCY == 1) begin
                            state_q <= RESP;
                            ready_q <= 1'b1;
                            rd_q    <= !mem_we_i;
                            oor_q   <= oor;
                            err_q   <= err_q | oor;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (commit) begin
                        cnt_q   <= 4'd0;
                        state_q <= RESP;
                        ready_q <= 1'b1;
                        rd_q    <= !we_q;
                        oor_q   <= oor;
                        err_q   <= err_q | oor;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                RESP: begin
                    ready_q <= 1'b0;
                    rd_q    <= 1'b0;
                    state_q <= RECOV;
                end
                RECOV: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_ready_o = ready_q;
    assign err_o       = err_q;
    assign mem_rdata_o = rd_q ? (oor_q ? ERR_WORD : sram_rdata) : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_responder                                                           |
// | Three responders (LATENCY 1, 3, 4) checked against a word-array model.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]       rst_n = 3'b000;
    logic [2:0]       valid = 3'b000;
    logic [2:0]       wen   = 3'b000;
    logic [2:0][15:0] addr  = '0;
    logic [2:0][31:0] wdat  = '0;
    wire  [2:0]       ready;
    wire  [2:0]       err;
    wire  [2:0][31:0] rdat;

    int checks = 0;
    int errors = 0;
    int lat_tab [3] = '{1, 3, 4};

    logic [31:0] mem_m   [3][1024];
    bit          known_m [3][1024];
    bit          err_m   [3];

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dut
            mem_responder #(
                .ADDR_WIDTH (16),
                .DATA_WIDTH (32),
                .DEPTH      (1024),
                .LATENCY    ((gi == 0) ? 1 : ((gi == 1) ? 3 : 4))
            ) u_dut (
                .clk_i       (clk),
                .rst_ni      (rst_n[gi]),
                .mem_valid_i (valid[gi]),
                .mem_ready_o (ready[gi]),
                .mem_we_i    (wen[gi]),
                .mem_adr_i   (addr[gi]),
                .mem_wdata_i (wdat[gi]),
                .mem_rdata_o (rdat[gi]),
                .err_o       (err[gi])
            );
        end
    endgenerate

    // One complete access; leaves the DUT back in IDLE.
    task automatic access(input int k, input logic we, input logic [15:0] adr,
                          input logic [31:0] wd, input bit drop, input bit scramble);
        int n;
        bit got;
        int idx;
        bit oor;
        logic [31:0] rd;
        logic [31:0] exp;
        n   = 0;
        got = 0;
        rd  = '0;
        @(negedge clk);
        valid[k] = 1'b1;
        wen[k]   = we;
        addr[k]  = adr;
        wdat[k]  = wd;
        while (!got && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (ready[k]) begin
                got = 1;
                rd  = rdat[k];
            end else begin
                if (drop) valid[k] = 1'b0;
                if (scramble) begin
                    addr[k] = 16'($urandom);
                    wdat[k] = $urandom;
                    wen[k]  = ~we;
                end
            end
        end
        valid[k] = 1'b0;
        idx = int'(adr) >> 2;
        oor = (idx >= 1024);
        if (oor) err_m[k] = 1;
        else if (we) begin
            mem_m[k][idx]   = wd;
            known_m[k][idx] = 1;
        end
        checks++;
        if (!got || n != lat_tab[k]) begin
            errors++;
            $display("FAIL latency k=%0d adr=%h got_ready=%0d cycles=%0d want=%0d", k, adr, got, n, lat_tab[k]);
        end
        if (!we && (oor || known_m[k][idx])) begin
            exp = oor ? 32'hDEADDEAD : mem_m[k][idx];
            checks++;
            if (rd !== exp) begin
                errors++;
                $display("FAIL rdata k=%0d adr=%h got=%h want=%h", k, adr, rd, exp);
            end
        end
        checks++;
        if (err[k] !== err_m[k]) begin
            errors++;
            $display("FAIL err k=%0d adr=%h got=%b want=%b", k, adr, err[k], err_m[k]);
        end
        @(posedge clk);
        #1;
        checks++;
        if (ready[k] !== 1'b0 || rdat[k] !== 32'h0) begin
            errors++;
            $display("FAIL after_resp k=%0d ready=%b rdata=%h want ready=0 rdata=0", k, ready[k], rdat[k]);
        end
        @(posedge clk);
    endtask

    task automatic test_reset();
        valid = 3'b111;
        wen   = 3'b101;
        for (int k = 0; k < 3; k++) begin
            addr[k] = 16'($urandom_range(0, 4095));
            wdat[k] = $urandom;
        end
        repeat (3) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (ready[k] !== 1'b0 || rdat[k] !== 32'h0 || err[k] !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_vals k=%0d ready=%b rdata=%h err=%b want 0/0/0", k, ready[k], rdat[k], err[k]);
                end
            end
        end
        valid = 3'b000;
        rst_n = 3'b111;
        repeat (5) begin
            @(negedge clk);
            checks++;
            if (ready !== 3'b000) begin
                errors++;
                $display("FAIL idle_after_reset ready=%b want=000", ready);
            end
        end
    endtask

    task automatic test_lat1_write_read();
        access(0, 1'b1, 16'h0010, 32'hABCD1234, 0, 0);
        access(0, 1'b0, 16'h0010, 32'h0, 0, 0);
    endtask

    task automatic test_back_to_back(input int k);
        int L;
        int nseen;
        int edge_at [2];
        logic [31:0] rd_at [2];
        logic [31:0] wv;
        L  = lat_tab[k];
        wv = $urandom;
        access(k, 1'b1, 16'h0040, wv, 0, 0);
        nseen = 0;
        edge_at = '{0, 0};
        rd_at   = '{32'h0, 32'h0};
        @(negedge clk);
        valid[k] = 1'b1;
        wen[k]   = 1'b0;
        addr[k]  = 16'h0040;
        for (int n = 1; n <= 2 * L + 4; n++) begin
            @(posedge clk);
            #1;
            if (ready[k]) begin
                if (nseen < 2) begin
                    edge_at[nseen] = n;
                    rd_at[nseen]   = rdat[k];
                end
                nseen++;
            end
        end
        valid[k] = 1'b0;
        repeat (2) @(posedge clk);
        checks++;
        if (nseen != 2 || edge_at[0] != L || edge_at[1] != 2 * L + 2) begin
            errors++;
            $display("FAIL b2b_timing k=%0d pulses=%0d at=%0d,%0d want 2 at %0d,%0d", k, nseen, edge_at[0], edge_at[1], L, 2 * L + 2);
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (rd_at[i] !== wv) begin
                errors++;
                $display("FAIL b2b_rdata k=%0d pulse=%0d got=%h want=%h", k, i, rd_at[i], wv);
            end
        end
    endtask

    task automatic test_out_of_range();
        access(0, 1'b1, 16'h0000, 32'hCAFEF00D, 0, 0);
        access(0, 1'b1, 16'h1000, 32'h12345678, 0, 0);
        access(0, 1'b0, 16'h0000, 32'h0, 0, 0);
        access(0, 1'b0, 16'h1000, 32'h0, 0, 0);
        access(0, 1'b0, 16'h0010, 32'h0, 0, 0);
    endtask

    task automatic write_with_reset(input int k, input logic [15:0] adr, input logic [31:0] wd);
        @(negedge clk);
        valid[k] = 1'b1;
        wen[k]   = 1'b1;
        addr[k]  = adr;
        wdat[k]  = wd;
        @(posedge clk);
        #1;
        valid[k] = 1'b0;
        rst_n[k] = 1'b0;
        #1;
        checks++;
        if (ready[k] !== 1'b0 || rdat[k] !== 32'h0 || err[k] !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset k=%0d ready=%b rdata=%h err=%b want 0/0/0", k, ready[k], rdat[k], err[k]);
        end
        @(negedge clk);
        rst_n[k] = 1'b1;
        err_m[k] = 0;
        @(posedge clk);
    endtask

    task automatic test_reset_mid_write();
        write_with_reset(1, 16'h0020, 32'h5A5A5A5A);
        access(1, 1'b1, 16'h0020, 32'h00000000, 0, 0);
        write_with_reset(1, 16'h0020, 32'h5A5A5A5A);
        access(1, 1'b0, 16'h0020, 32'h0, 0, 0);
    endtask

    task automatic test_latched_fields();
        access(2, 1'b1, 16'h0030, 32'h11111111, 0, 1);
        access(2, 1'b0, 16'h0030, 32'h0, 0, 0);
        access(1, 1'b1, 16'h0030, 32'h11111111, 1, 1);
        access(1, 1'b0, 16'h0030, 32'h0, 0, 0);
    endtask

    task automatic test_random(input int k, input int count);
        int r;
        int idx;
        logic [15:0] adr;
        for (int i = 0; i < count; i++) begin
            r   = $urandom_range(0, 99);
            idx = $urandom_range(0, 63);
            adr = 16'(idx * 4 + $urandom_range(0, 3));
            if (r < 35) begin
                access(k, 1'b1, adr, $urandom, 0, 0);
            end else if (r < 75) begin
                if (known_m[k][idx]) access(k, 1'b0, adr, $urandom, 0, 0);
                else access(k, 1'b1, adr, $urandom, 0, 0);
            end else if (r < 85) begin
                adr = 16'($urandom_range(4096, 65535));
                access(k, r[0], adr, $urandom, 0, 0);
            end else begin
                access(k, 1'b1, adr, $urandom, r[0], 1);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            err_m[k] = 0;
            for (int i = 0; i < 1024; i++) begin
                known_m[k][i] = 0;
                mem_m[k][i]   = '0;
            end
        end
        test_reset();
        test_lat1_write_read();
        test_back_to_back(2);
        test_back_to_back(1);
        test_out_of_range();
        test_reset_mid_write();
        test_latched_fields();
        for (int k = 0; k < 3; k++) test_random(k, 40);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
